// File: rtl/pipe_addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encodings,
// the NZCV flag bundle and the initial carry selection.
package pipe_addsub_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // SUB forms A + ~B + 1; the carry ops take the caller's carry instead.
  function automatic logic carry_in0(input logic [1:0] op, input logic cin);
    case (op)
      OP_ADD:  return 1'b0;
      OP_SUB:  return 1'b1;
      default: return cin;
    endcase
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the ripple slices.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipe_addsub_slice.sv
// SW-bit ripple adder slice built from full_adder cells; also exposes the
// carry into its top bit so the final slice can form signed overflow.
module addsub_slice #(
  parameter int SW = 16
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          msb_cin
);

  logic [SW:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SW; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout    = c[SW];
  assign msb_cin = c[SW-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract unit with NZCV flags and valid/ready on both sides.
// Define PIPE_ADDSUB_SAT_EN to add the 'sat' input and signed-saturation clamp.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
`ifdef PIPE_ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int SW = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_addsub: need WIDTH >= 2, 1 <= STAGES <= WIDTH, WIDTH %% STAGES == 0");
  end

  // Per-stage register contents, exported so the next stage can read them.
  logic [STAGES-1:0] vv, cv, msbcv, ld;
  logic [WIDTH-1:0]  av [STAGES];
  logic [WIDTH-1:0]  bv [STAGES];
  logic [WIDTH-1:0]  sv [STAGES];
  logic [1:0]        opv [STAGES];
`ifdef PIPE_ADDSUB_SAT_EN
  logic [STAGES-1:0] satv;
`endif

  // A stage may load when it is empty or its occupant is leaving this cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    ld = '0;
    ld[STAGES-1] = !vv[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) ld[k] = !vv[k] || ld[k+1];
  end

  assign in_ready = ld[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_in, c_in, cout, msb_cin;
    logic [WIDTH-1:0] a_in, b_in, sum_in, sum_nxt;
    logic [1:0]       op_in;
    logic [SW-1:0]    xb_chunk, sum_chunk;
    logic             v_q, c_q, msbc_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [1:0]       op_q;
`ifdef PIPE_ADDSUB_SAT_EN
    logic             sat_in, sat_q;
`endif

    if (k == 0) begin : g_head
      assign v_in   = in_valid;
      assign a_in   = a;
      assign b_in   = b;
      assign op_in  = op;
      assign c_in   = carry_in0(op, cin);
      assign sum_in = '0;
`ifdef PIPE_ADDSUB_SAT_EN
      assign sat_in = sat;
`endif
    end else begin : g_body
      assign v_in   = vv[k-1];
      assign a_in   = av[k-1];
      assign b_in   = bv[k-1];
      assign op_in  = opv[k-1];
      assign c_in   = cv[k-1];
      assign sum_in = sv[k-1];
`ifdef PIPE_ADDSUB_SAT_EN
      assign sat_in = satv[k-1];
`endif
    end

    assign xb_chunk = op_in[0] ? ~b_in[k*SW +: SW] : b_in[k*SW +: SW];

    addsub_slice #(.SW(SW)) u_slice (
      .a       (a_in[k*SW +: SW]),
      .b       (xb_chunk),
      .cin     (c_in),
      .sum     (sum_chunk),
      .cout    (cout),
      .msb_cin (msb_cin)
    );

    always_comb begin
      sum_nxt = sum_in;
      sum_nxt[k*SW +: SW] = sum_chunk;
    end

    // NOTE: datapath registers are reset as well, so sum and flags read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        v_q    <= 1'b0;
        a_q    <= '0;
        b_q    <= '0;
        sum_q  <= '0;
        op_q   <= '0;
        c_q    <= 1'b0;
        msbc_q <= 1'b0;
`ifdef PIPE_ADDSUB_SAT_EN
        sat_q  <= 1'b0;
`endif
      end else if (ld[k]) begin
        v_q <= v_in;
        // Payload only moves with a real transaction so a stalled result stays put.
        if (v_in) begin
          a_q    <= a_in;
          b_q    <= b_in;
          sum_q  <= sum_nxt;
          op_q   <= op_in;
          c_q    <= cout;
          msbc_q <= msb_cin;
`ifdef PIPE_ADDSUB_SAT_EN
          sat_q  <= sat_in;
`endif
        end
      end
    end

    assign vv[k]    = v_q;
    assign av[k]    = a_q;
    assign bv[k]    = b_q;
    assign sv[k]    = sum_q;
    assign opv[k]   = op_q;
    assign cv[k]    = c_q;
    assign msbcv[k] = msbc_q;
`ifdef PIPE_ADDSUB_SAT_EN
    assign satv[k]  = sat_q;
`endif
  end

  logic [WIDTH-1:0] res;
  flags_t           fl;

  // Flags come straight from the last stage; they read 0 while it is empty.
  always_comb begin
    res  = sv[STAGES-1];
    fl   = '0;
    fl.c = cv[STAGES-1];
    fl.v = msbcv[STAGES-1] ^ cv[STAGES-1];
`ifdef PIPE_ADDSUB_SAT_EN
    if (satv[STAGES-1] && fl.v)
      res = av[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    fl.n = res[WIDTH-1];
    fl.z = (res == '0);
    if (!vv[STAGES-1]) fl = '0;
  end

  assign out_valid = vv[STAGES-1];
  assign sum       = res;
  assign flag_n    = fl.n;
  assign flag_z    = fl.z;
  assign flag_c    = fl.c;
  assign flag_v    = fl.v;

  // The last stage's operands and op have no consumer downstream.
  logic unused_bits;
  assign unused_bits = ^{av[STAGES-1], bv[STAGES-1], opv[STAGES-1], msbcv};

endmodule
